// File: rtl/mc_ctrl_hs.sv
// mc_ctrl_hs: multicycle CPU control FSM with a request/ready memory handshake.
// Instruction fetch takes IR_BEATS memory beats, and each beat loads one IR lane.
// Memory may stall any request for any number of cycles via mem_ready.
// Optional build macro MC_CTRL_TRAP_EN: an undefined opcode redirects the PC
// to the trap vector. When the macro is undefined, the opcode retires as a NOP.
// state_o encoding (debug): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4,
// MEMWR=5, REX=6, RWB=7, IEX=8, IWB=9, BR=10, JMP=11, PUSHW=12, POPR=13, ILL=14.
module mc_ctrl_hs #(
  parameter int unsigned    OPW      = 6,
  parameter int unsigned    IR_BEATS = 4,
  parameter logic [OPW-1:0] OP_RTYPE = OPW'(0),
  parameter logic [OPW-1:0] OP_LW    = OPW'(35),
  parameter logic [OPW-1:0] OP_SW    = OPW'(43),
  parameter logic [OPW-1:0] OP_BEQ   = OPW'(4),
  parameter logic [OPW-1:0] OP_BNE   = OPW'(5),
  parameter logic [OPW-1:0] OP_ADDI  = OPW'(8),
  parameter logic [OPW-1:0] OP_J     = OPW'(2),
  parameter logic [OPW-1:0] OP_PUSH  = OPW'(56),
  parameter logic [OPW-1:0] OP_POP   = OPW'(57)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPW-1:0]      op,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic [IR_BEATS-1:0] irwrite,
  output logic                pcen,
  output logic [1:0]          pcsrc,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [1:0]          aluop,
  output logic                regwrite,
  output logic                regdst,
  output logic                memtoreg,
  output logic                sp_ld,
  output logic                sp_dec,
  output logic                instr_done,
  output logic                illegal,
  output logic [4:0]          state_o
);

  // The beat counter is at least one bit wide, so IR_BEATS=1 is legal.
  localparam int unsigned    BW        = (IR_BEATS > 1) ? $clog2(IR_BEATS) : 1;
  localparam logic [BW-1:0]  LAST_BEAT = BW'(IR_BEATS - 1);

  typedef enum logic [4:0] {
    S_FETCH  = 5'd0,
    S_DECODE = 5'd1,
    S_MEMADR = 5'd2,
    S_MEMRD  = 5'd3,
    S_MEMWB  = 5'd4,
    S_MEMWR  = 5'd5,
    S_REX    = 5'd6,
    S_RWB    = 5'd7,
    S_IEX    = 5'd8,
    S_IWB    = 5'd9,
    S_BR     = 5'd10,
    S_JMP    = 5'd11,
    S_PUSHW  = 5'd12,
    S_POPR   = 5'd13,
    S_ILL    = 5'd14
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;

  // State register: current FSM state and the fetch beat counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the pre-edge values and the order of statements does not matter.
    if (reset) begin
      state_q <= S_FETCH;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state logic: memory states advance only when mem_ready completes them.
  always_comb begin
    // NOTE: a default for every variable assigned here keeps this block
    // purely combinational; a missing branch would otherwise infer a latch.
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_DECODE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      S_DECODE: begin
        // If-chain gives a defined priority should two opcode parameters collide.
        if (op == OP_LW || op == OP_SW) begin
          state_d = S_MEMADR;
        end else if (op == OP_RTYPE) begin
          state_d = S_REX;
        end else if (op == OP_BEQ || op == OP_BNE) begin
          state_d = S_BR;
        end else if (op == OP_ADDI) begin
          state_d = S_IEX;
        end else if (op == OP_J) begin
          state_d = S_JMP;
        end else if (op == OP_PUSH) begin
          state_d = S_PUSHW;
        end else if (op == OP_POP) begin
          state_d = S_POPR;
        end else begin
          state_d = S_ILL;
        end
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_REX:    state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_IEX:    state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_BR:     state_d = S_FETCH;
      S_JMP:    state_d = S_FETCH;
      S_PUSHW:  if (mem_ready) state_d = S_FETCH;
      S_POPR:   if (mem_ready) state_d = S_MEMWB;
      S_ILL:    state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output logic: all controls are decoded from the state and are forced low during reset.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    irwrite    = '0;
    pcen       = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    sp_ld      = 1'b0;
    sp_dec     = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    state_o    = '0;
    if (!reset) begin
      state_o = state_q;
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          // Enables and the PC+1 path are active only on the accepting beat.
          if (mem_ready) begin
            irwrite[beat_q] = 1'b1;
            pcen            = 1'b1;
            alusrcb         = 2'b01;
          end
        end
        S_DECODE: begin
          // Speculative branch target goes into ALUOut.
          alusrcb = 2'b11;
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: begin
          iord    = 1'b1;
          mem_req = 1'b1;
        end
        S_MEMWB: begin
          regwrite   = 1'b1;
          memtoreg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          iord       = 1'b1;
          mem_req    = 1'b1;
          mem_we     = 1'b1;
          instr_done = mem_ready;
        end
        S_REX: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
        end
        S_RWB: begin
          regwrite   = 1'b1;
          regdst     = 1'b1;
          instr_done = 1'b1;
        end
        S_IEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_IWB: begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BR: begin
          alusrca    = 1'b1;
          aluop      = 2'b01;
          pcsrc      = 2'b01;
          pcen       = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
          instr_done = 1'b1;
        end
        S_JMP: begin
          pcsrc      = 2'b10;
          pcen       = 1'b1;
          instr_done = 1'b1;
        end
        S_PUSHW: begin
          // SP moves only once the write has been accepted.
          iord       = 1'b1;
          mem_req    = 1'b1;
          mem_we     = 1'b1;
          sp_ld      = mem_ready;
          sp_dec     = mem_ready;
          instr_done = mem_ready;
        end
        S_POPR: begin
          iord    = 1'b1;
          mem_req = 1'b1;
          sp_ld   = mem_ready;
        end
        S_ILL: begin
`ifdef MC_CTRL_TRAP_EN
          illegal = 1'b1;
          pcsrc   = 2'b11;
          pcen    = 1'b1;
`else
          illegal    = 1'b1;
          instr_done = 1'b1;
`endif
        end
        default: begin
          state_o = state_q;
        end
      endcase
    end
  end

endmodule
